// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t     : FSM encoding (IDLE / ACCESS / RESP)
//   TIMEOUT_DEF : default ack wait limit in cycles
//   ALIGN_MASK  : address bits that must be zero for a word access
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int         TIMEOUT_DEF = 255;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/mem_wait_counter.sv
// Ack wait counter for the memory-access stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (entry to ACCESS)
//   en         : count one cycle spent waiting without ack
//   tc         : high during the final allowed wait cycle (count == TIMEOUT-1)
module mem_wait_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Terminal one cycle early so the request is high for exactly TIMEOUT cycles.
  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: accepts one execute-stage result at a time,
// performs an optional word load/store over a req/ack data-memory port, and
// issues a single-cycle writeback strobe with error pulses for misaligned or
// timed-out accesses.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_*                : execute-stage result and control flags
//   ex_ready            : stage is idle and can accept a new entry
//   dmem_*              : data-memory request/response port
//   wb_valid/wb_en      : writeback strobe and register-write enable
//   wb_rd/wb_data       : writeback destination and value (held between strobes)
//   misalign_err        : one-cycle pulse for a misaligned load/store
//   timeout_err         : one-cycle pulse when ack did not arrive in TIMEOUT cycles
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_write_reg,
  input  logic        ex_load_en,
  input  logic        ex_store_en,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_store_data,
  output logic        ex_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  state_t      state, state_nx;
  logic        accept;
  logic        mem_op;
  logic        misaligned;
  logic        access_done;
  logic        access_timeout;
  logic        wait_tc;

  // Fields captured at accept, needed when a memory access completes.
  logic [4:0]  rd_p1;
  logic        wen_p1;
  logic        load_p1;

  assign ex_ready   = (state == ST_IDLE);
  assign accept     = ex_valid && ex_ready;
  assign mem_op     = ex_load_en || ex_store_en;
  assign misaligned = |(ex_res[1:0] & ALIGN_MASK);

  mem_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    ((state == ST_ACCESS) && !dmem_ack),
    .tc    (wait_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    access_done    = 1'b0;
    access_timeout = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = (mem_op && !misaligned) ? ST_ACCESS : ST_RESP;
        end
      end
      ST_ACCESS: begin
        // Ack wins over timeout when both land in the last wait cycle.
        if (dmem_ack) begin
          state_nx    = ST_RESP;
          access_done = 1'b1;
        end else if (wait_tc) begin
          state_nx       = ST_RESP;
          access_timeout = 1'b1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: capture at accept, drive memory port and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1        <= '0;
      wen_p1       <= 1'b0;
      load_p1      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;

      if (accept) begin
        rd_p1   <= ex_rd;
        wen_p1  <= ex_write_reg && (ex_rd != 5'd0);
        load_p1 <= ex_load_en;
        if (!mem_op) begin
          wb_valid <= 1'b1;
          wb_en    <= ex_write_reg && (ex_rd != 5'd0);
          wb_rd    <= ex_rd;
          wb_data  <= ex_res;
        end else if (misaligned) begin
          wb_valid     <= 1'b1;
          wb_rd        <= ex_rd;
          misalign_err <= 1'b1;
        end else begin
          dmem_req   <= 1'b1;
          dmem_we    <= !ex_load_en;
          dmem_addr  <= ex_res;
          dmem_wdata <= ex_store_data;
        end
      end

      if (access_done) begin
        dmem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_rd    <= rd_p1;
        wb_en    <= load_p1 && wen_p1;
        if (load_p1) begin
          wb_data <= dmem_rdata;
        end
      end

      if (access_timeout) begin
        dmem_req    <= 1'b0;
        wb_valid    <= 1'b1;
        wb_rd       <= rd_p1;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_write_reg, ex_load_en, ex_store_en;
  logic [4:0]  ex_rd;
  logic [31:0] ex_res, ex_store_data;
  logic        ex_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_write_reg  (ex_write_reg),
    .ex_load_en    (ex_load_en),
    .ex_store_en   (ex_store_en),
    .ex_rd         (ex_rd),
    .ex_res        (ex_res),
    .ex_store_data (ex_store_data),
    .ex_ready      (ex_ready),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic        wr;
    logic        ld;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        exp_en;
    logic        exp_mis;
    logic        chk_data;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_write_reg  = 1'b0;
    ex_load_en    = 1'b0;
    ex_store_en   = 1'b0;
    ex_rd         = 5'd0;
    ex_res        = 32'h0;
    ex_store_data = 32'h0;
  endtask

  task automatic drive(input logic wr, input logic ld, input logic st, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd);
    ex_valid      = 1'b1;
    ex_write_reg  = wr;
    ex_load_en    = ld;
    ex_store_en   = st;
    ex_rd         = rd;
    ex_res        = res;
    ex_store_data = sd;
  endtask

  logic [31:0] last_data;

  initial begin
    //               wr    ld    st    rd     res           en    mis   chkd
    vt[0] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_0010, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000_AAAA, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0055, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h0000_0102, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_0101, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 5'd8,  32'h0000_0003, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};

    idle_inputs();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    rst_n      = 1'b0;
    #2;
    chk("reset ex_ready", 32'(ex_ready), 32'd1);
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_data",  wb_data,       32'h0);
    chk("reset errs",     32'({misalign_err, timeout_err}), 32'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Single-cycle ops: non-memory results and misaligned accesses.
    last_data = 32'h0;
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].wr, vt[i].ld, vt[i].st, vt[i].rd, vt[i].res, 32'hCAFE_0000);
      step();
      idle_inputs();
      chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d wb_en", i), 32'(wb_en), 32'(vt[i].exp_en));
      chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(vt[i].rd));
      chk($sformatf("v%0d misalign", i), 32'(misalign_err), 32'(vt[i].exp_mis));
      chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d ex_ready busy", i), 32'(ex_ready), 32'd0);
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d wb_data", i), wb_data, vt[i].res);
        last_data = vt[i].res;
      end
      step();
      chk($sformatf("v%0d wb_valid drop", i), 32'(wb_valid), 32'd0);
      chk($sformatf("v%0d misalign drop", i), 32'(misalign_err), 32'd0);
      chk($sformatf("v%0d ex_ready idle", i), 32'(ex_ready), 32'd1);
      chk($sformatf("v%0d dmem_req idle", i), 32'(dmem_req), 32'd0);
      if (vt[i].chk_data) chk($sformatf("v%0d wb_data hold", i), wb_data, last_data);
    end

    // Ack while idle must be ignored.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1111_1111;
    step();
    dmem_ack = 1'b0;
    chk("idle ack wb_valid", 32'(wb_valid), 32'd0);
    chk("idle ack ex_ready", 32'(ex_ready), 32'd1);

    // LW 0x100, ack in the third request cycle.
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0100, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      chk($sformatf("lw req c%0d", c), 32'(dmem_req), 32'd1);
      chk($sformatf("lw addr c%0d", c), dmem_addr, 32'h0000_0100);
      chk($sformatf("lw we c%0d", c), 32'(dmem_we), 32'd0);
      chk($sformatf("lw ex_ready c%0d", c), 32'(ex_ready), 32'd0);
      chk($sformatf("lw wb_valid c%0d", c), 32'(wb_valid), 32'd0);
      if (c == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
    end
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    chk("lw req drop",  32'(dmem_req), 32'd0);
    chk("lw wb_valid",  32'(wb_valid), 32'd1);
    chk("lw wb_en",     32'(wb_en),    32'd1);
    chk("lw wb_rd",     32'(wb_rd),    32'd9);
    chk("lw wb_data",   wb_data,       32'hDEAD_BEEF);
    chk("lw ex_ready",  32'(ex_ready), 32'd0);
    step();
    chk("lw wb_valid drop", 32'(wb_valid), 32'd0);
    chk("lw data hold",     wb_data,       32'hDEAD_BEEF);
    chk("lw ex_ready idle", 32'(ex_ready), 32'd1);

    // SW 0x104, ack in the first ACCESS cycle.
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0104, 32'h1234_5678);
    step();
    idle_inputs();
    chk("sw req",   32'(dmem_req), 32'd1);
    chk("sw we",    32'(dmem_we),  32'd1);
    chk("sw addr",  dmem_addr,     32'h0000_0104);
    chk("sw wdata", dmem_wdata,    32'h1234_5678);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_5555;
    step();
    dmem_ack = 1'b0;
    chk("sw req drop", 32'(dmem_req), 32'd0);
    chk("sw wb_valid", 32'(wb_valid), 32'd1);
    chk("sw wb_en",    32'(wb_en),    32'd0);
    chk("sw wb_data",  wb_data,       32'hDEAD_BEEF);
    step();
    chk("sw wb_valid drop", 32'(wb_valid), 32'd0);

    // LW 0x200 with no ack: 8 request cycles then timeout.
    drive(1'b1, 1'b1, 1'b0, 5'd12, 32'h0000_0200, 32'h0);
    for (int c = 0; c < 8; c++) begin
      step();
      idle_inputs();
      chk($sformatf("to req c%0d", c), 32'(dmem_req), 32'd1);
      chk($sformatf("to err c%0d", c), 32'(timeout_err), 32'd0);
    end
    step();
    chk("to req drop",  32'(dmem_req),    32'd0);
    chk("to err pulse", 32'(timeout_err), 32'd1);
    chk("to wb_valid",  32'(wb_valid),    32'd1);
    chk("to wb_en",     32'(wb_en),       32'd0);
    step();
    chk("to err drop",  32'(timeout_err), 32'd0);
    chk("to wb_valid drop", 32'(wb_valid), 32'd0);
    chk("to ex_ready",  32'(ex_ready),    32'd1);

    // Reset two cycles into ACCESS aborts the request immediately.
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0300, 32'h0);
    step();
    idle_inputs();
    chk("rst req c0", 32'(dmem_req), 32'd1);
    step();
    chk("rst req c1", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst req async",  32'(dmem_req), 32'd0);
    chk("rst ex_ready",   32'(ex_ready), 32'd1);
    step();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("rst post wb_valid c%0d", c), 32'(wb_valid), 32'd0);
      chk($sformatf("rst post timeout c%0d", c), 32'(timeout_err), 32'd0);
      chk($sformatf("rst post req c%0d", c), 32'(dmem_req), 32'd0);
    end
    chk("rst post ex_ready", 32'(ex_ready), 32'd1);

    // Back-to-back after reset still works.
    drive(1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0042, 32'h0);
    step();
    idle_inputs();
    chk("post rst wb_valid", 32'(wb_valid), 32'd1);
    chk("post rst wb_data",  wb_data,       32'h0000_0042);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, 255: max cycles dmem_req may wait for dmem_ack before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  execute-stage result valid this cycle.
REQ-005 ex_write_reg / ex_load_en / ex_store_en  in  1 each  control flags from execute stage.
REQ-006 ex_rd  in  5  destination register index.
REQ-007 ex_res  in  32  ALU result, or effective address for load/store.
REQ-008 ex_store_data  in  32  store write data.
REQ-009 ex_ready  out  1  stage can accept a new entry.
REQ-010 dmem_req / dmem_we  out  1 each  data-memory request, write enable.
REQ-011 dmem_addr / dmem_wdata  out  32 each  word address, write data.
REQ-012 dmem_ack  in  1  memory completion; dmem_rdata  in  32  load data, valid with ack.
REQ-013 wb_valid / wb_en  out  1 each  writeback strobe, register-write enable.
REQ-014 wb_rd  out  5; wb_data  out  32  writeback destination and value.
REQ-015 misalign_err / timeout_err  out  1 each  one-cycle error pulses.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP; ex_ready = (state==IDLE).
REQ-017 Accept = ex_valid & ex_ready at rising edge; inputs captured into internal registers.
REQ-018 Accepted non-memory op: -> RESP; next cycle wb_valid=1, wb_en=ex_write_reg, wb_data=ex_res (latency 1).
REQ-019 Accepted load or store with ex_res[1:0]!=0: no memory access; -> RESP; next cycle misalign_err=1, wb_valid=1, wb_en=0.
REQ-020 Accepted aligned load/store: -> ACCESS; dmem_req=1 from next cycle, addr/we/wdata held stable until ack or timeout.
REQ-021 ex_load_en and ex_store_en both set: treated as load.
REQ-022 ACCESS with dmem_ack=1 (first ACCESS cycle included): dmem_req drops next cycle; -> RESP; load: wb_data=dmem_rdata, wb_en=ex_write_reg; store: wb_en=0.
REQ-023 Wait counter cleared on entry to ACCESS, increments each cycle without ack; reaching TIMEOUT: deassert req, -> RESP, timeout_err=1, wb_valid=1, wb_en=0.
REQ-024 RESP lasts exactly one cycle, then -> IDLE; wb_valid and error outputs are single-cycle pulses.
REQ-025 wb_en forced 0 when captured ex_rd==0.
REQ-026 dmem_ack in IDLE or RESP ignored.
REQ-027 Maximum throughput: one op per 2 cycles (non-memory); memory op occupies 2 + wait cycles.
REQ-028 wb_rd/wb_data hold last values when wb_valid=0.

Reset
REQ-029 rst_n low forces immediately: state=IDLE, counter=0, all outputs 0 except ex_ready=1.
REQ-030 Reset during ACCESS aborts the request asynchronously; no wb_valid or error pulse issued for the aborted op.

Structure
REQ-031 Shared package mem_pkg holds FSM state encoding, TIMEOUT default, alignment-mask constant.
REQ-032 Wait counter implemented as sub-module mem_wait_counter (clear, enable, terminal-count output).

Verification
REQ-033 ADD result: ex_valid, ex_write_reg=1, ex_rd=5, ex_res=0x0000_0010 -> next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x10; no dmem_req.
REQ-034 LW addr 0x100, ack 3 cycles after req, rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, addr 0x100, we=0; wb_data=0xDEAD_BEEF cycle after ack; ex_ready low throughout.
REQ-035 SW addr 0x104, data 0x1234_5678, ack in first ACCESS cycle -> one-cycle req, we=1, wdata=0x1234_5678; wb_valid=1, wb_en=0.
REQ-036 LW addr 0x102 -> misalign_err pulse, wb_en=0, dmem_req never asserted.
REQ-037 LW addr 0x200, ack never, TIMEOUT=8 -> req high 8 cycles, then timeout_err pulse, wb_en=0, return to IDLE.
REQ-038 rst_n low 2 cycles into ACCESS -> dmem_req low same cycle, state IDLE, no wb_valid after release.
